// File: rtl/unified_mem_arbiter.sv
// Arbiter sharing one single-ported, variable-latency memory bus between the
// RV32 fetch (IF) and load/store (LS) requesters, one transaction at a time.
module unified_mem_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  output logic        if_err,
  input  logic        ls_req,
  input  logic        ls_we,
  input  logic [31:0] ls_addr,
  input  logic [31:0] ls_wdata,
  output logic        ls_gnt,
  output logic        ls_rvalid,
  output logic [31:0] ls_rdata,
  output logic        ls_err,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rdata,
  output logic        busy
);

  localparam int SC_W = $clog2(STARVE_LIMIT + 1);
  localparam int WC_W = $clog2(TIMEOUT);
  localparam logic [SC_W-1:0] STARVE_MAX = SC_W'(STARVE_LIMIT);
  localparam logic [WC_W-1:0] WAIT_LAST  = WC_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t            state_r;
  logic [SC_W-1:0]   starve_cnt_r;
  logic [WC_W-1:0]   wait_cnt_r;
  logic              owner_ls_r;
  logic              we_r;
  logic [31:0]       addr_r;
  logic [31:0]       wdata_r;
  logic [31:0]       rdata_r;
  logic              err_r;

  logic              idle_s;
  logic              if_win_s;
  logic              resp_s;
  logic [31:0]       gnt_addr_s;

  // Grants are gated by reset_n so every output reads 0 while reset is held.
  assign idle_s     = reset_n & (state_r == IDLE);
  assign if_win_s   = if_req & (~ls_req | (starve_cnt_r == STARVE_MAX));
  assign if_gnt     = idle_s & if_win_s;
  assign ls_gnt     = idle_s & ls_req & ~if_win_s;
  assign gnt_addr_s = ls_gnt ? ls_addr : if_addr;

  // Transaction sequencer: capture on grant, issue, wait with timeout, respond.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r      <= IDLE;
      starve_cnt_r <= '0;
      wait_cnt_r   <= '0;
      owner_ls_r   <= 1'b0;
      we_r         <= 1'b0;
      addr_r       <= 32'd0;
      wdata_r      <= 32'd0;
      rdata_r      <= 32'd0;
      err_r        <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (if_gnt || ls_gnt) begin
            owner_ls_r <= ls_gnt;
            addr_r     <= gnt_addr_s;
            we_r       <= ls_gnt & ls_we;
            wdata_r    <= ls_gnt ? ls_wdata : 32'd0;
            if (if_gnt || !if_req) begin
              starve_cnt_r <= '0;
            end else if (starve_cnt_r != STARVE_MAX) begin
              starve_cnt_r <= starve_cnt_r + SC_W'(1);
            end
            if (gnt_addr_s[1:0] == 2'b00) begin
              state_r <= REQ;
            end else begin
              // Misaligned: trap straight to the response, memory untouched.
              rdata_r <= 32'd0;
              err_r   <= 1'b1;
              state_r <= RESP;
            end
          end
        end
        REQ: begin
          if (mem_req_ready) begin
            wait_cnt_r <= '0;
            state_r    <= WAIT;
          end
        end
        WAIT: begin
          if (mem_rsp_valid) begin
            rdata_r <= we_r ? 32'd0 : mem_rdata;
            err_r   <= 1'b0;
            state_r <= RESP;
          end else if (wait_cnt_r == WAIT_LAST) begin
            rdata_r <= 32'd0;
            err_r   <= 1'b1;
            state_r <= RESP;
          end else begin
            wait_cnt_r <= wait_cnt_r + WC_W'(1);
          end
        end
        RESP: begin
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign busy          = (state_r != IDLE);
  assign mem_req_valid = (state_r == REQ);
  assign mem_we        = we_r;
  assign mem_addr      = addr_r;
  assign mem_wdata     = wdata_r;

  assign resp_s    = (state_r == RESP);
  assign if_rvalid = resp_s & ~owner_ls_r;
  assign ls_rvalid = resp_s & owner_ls_r;
  assign if_rdata  = if_rvalid ? rdata_r : 32'd0;
  assign ls_rdata  = ls_rvalid ? rdata_r : 32'd0;
  assign if_err    = if_rvalid & err_r;
  assign ls_err    = ls_rvalid & err_r;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed self-checking bench for unified_mem_arbiter (STARVE_LIMIT=4, TIMEOUT=16).
module tb_unified_mem_arbiter;

  logic        clk;
  logic        reset_n;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        if_err;
  logic        ls_req;
  logic        ls_we;
  logic [31:0] ls_addr;
  logic [31:0] ls_wdata;
  logic        ls_gnt;
  logic        ls_rvalid;
  logic [31:0] ls_rdata;
  logic        ls_err;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_rsp_valid;
  logic [31:0] mem_rdata;
  logic        busy;

  int checks = 0;
  int errors = 0;

  logic [136:0] all_out;
  assign all_out = {if_gnt, if_rvalid, if_rdata, if_err, ls_gnt, ls_rvalid, ls_rdata, ls_err,
                    mem_req_valid, mem_we, mem_addr, mem_wdata, busy};

  unified_mem_arbiter #(.STARVE_LIMIT(4), .TIMEOUT(16)) dut (
    .clk(clk), .reset_n(reset_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
    .if_rdata(if_rdata), .if_err(if_err),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata), .ls_err(ls_err),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rsp_valid(mem_rsp_valid),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge; inputs change here, outputs are sampled at negedge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    if_req = 1'b1; if_addr = 32'h0000_0010;
    ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h0000_0020; ls_wdata = 32'd0;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rdata = 32'd0;
    #3;
    checks++;
    if (all_out !== 137'd0) begin
      errors++; $display("FAIL reset_outputs: got %h expected 0", all_out);
    end
    if_req = 1'b0; ls_req = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_single_fetch();
    if_req = 1'b1; if_addr = 32'h0000_0010;
    @(negedge clk);
    checks++;
    if ({if_gnt, ls_gnt, busy} !== 3'b100) begin
      errors++; $display("FAIL fetch_gnt: got gnt/lsgnt/busy=%b expected 100", {if_gnt, ls_gnt, busy});
    end
    step();
    if_req = 1'b0; mem_req_ready = 1'b1;
    @(negedge clk);
    checks++;
    if ({mem_req_valid, mem_we, busy, mem_addr} !== {3'b101, 32'h0000_0010}) begin
      errors++; $display("FAIL fetch_req: got v/we/busy=%b addr=%h expected 101 addr=00000010",
                         {mem_req_valid, mem_we, busy}, mem_addr);
    end
    step();
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b1; mem_rdata = 32'h0050_0093;
    @(negedge clk);
    checks++;
    if ({mem_req_valid, busy, if_rvalid} !== 3'b010) begin
      errors++; $display("FAIL fetch_wait: got v/busy/rvalid=%b expected 010", {mem_req_valid, busy, if_rvalid});
    end
    step();
    mem_rsp_valid = 1'b0; mem_rdata = 32'd0;
    @(negedge clk);
    checks++;
    if ({if_rvalid, if_err, ls_rvalid, busy, if_rdata} !== {4'b1001, 32'h0050_0093}) begin
      errors++; $display("FAIL fetch_resp: got rv/err/lsrv/busy=%b data=%h expected 1001 data=00500093",
                         {if_rvalid, if_err, ls_rvalid, busy}, if_rdata);
    end
    step();
    @(negedge clk);
    checks++;
    if ({busy, if_rvalid} !== 2'b00) begin
      errors++; $display("FAIL fetch_idle: got busy/rvalid=%b expected 00", {busy, if_rvalid});
    end
  endtask

  task automatic test_simultaneous();
    step();
    if_req = 1'b1; if_addr = 32'h0000_0004;
    ls_req = 1'b1; ls_we = 1'b1; ls_addr = 32'h0000_0020; ls_wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    checks++;
    if ({ls_gnt, if_gnt} !== 2'b10) begin
      errors++; $display("FAIL simul_gnt: got ls/if=%b expected 10", {ls_gnt, if_gnt});
    end
    step();
    ls_req = 1'b0; ls_we = 1'b0; ls_wdata = 32'd0; mem_req_ready = 1'b1;
    @(negedge clk);
    checks++;
    if ({mem_req_valid, mem_we, mem_addr, mem_wdata} !== {2'b11, 32'h0000_0020, 32'hDEAD_BEEF}) begin
      errors++; $display("FAIL simul_store_req: got v/we=%b addr=%h wdata=%h expected 11 00000020 deadbeef",
                         {mem_req_valid, mem_we}, mem_addr, mem_wdata);
    end
    step();
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b1; mem_rdata = 32'h1234_5678;
    step();
    mem_rsp_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({ls_rvalid, ls_err, if_rvalid, if_gnt, ls_rdata} !== {4'b1000, 32'd0}) begin
      errors++; $display("FAIL simul_store_resp: got lsrv/err/ifrv/ifgnt=%b data=%h expected 1000 data=0",
                         {ls_rvalid, ls_err, if_rvalid, if_gnt}, ls_rdata);
    end
    step();
    @(negedge clk);
    checks++;
    if ({if_gnt, ls_gnt} !== 2'b10) begin
      errors++; $display("FAIL simul_if_next: got if/ls=%b expected 10", {if_gnt, ls_gnt});
    end
    step();
    if_req = 1'b0; mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b1; mem_rdata = 32'h0000_0011;
    step();
    mem_rsp_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({if_rvalid, if_err, if_rdata} !== {2'b10, 32'h0000_0011}) begin
      errors++; $display("FAIL simul_if_resp: got rv/err=%b data=%h expected 10 data=00000011",
                         {if_rvalid, if_err}, if_rdata);
    end
    step();
  endtask

  task automatic test_starvation();
    logic [9:0] order;
    int         ngnt;
    order = 10'd0; ngnt = 0;
    if_req = 1'b1; if_addr = 32'h0000_0100;
    ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h0000_0200;
    mem_req_ready = 1'b1; mem_rsp_valid = 1'b1; mem_rdata = 32'h0000_00AA;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if ((if_gnt || ls_gnt) && ngnt < 10) begin
        order[ngnt] = if_gnt;
        ngnt++;
      end
      step();
    end
    if_req = 1'b0; ls_req = 1'b0; mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rdata = 32'd0;
    checks++;
    if (ngnt != 10 || order !== 10'b10_0001_0000) begin
      errors++; $display("FAIL starve_order: got %0d grants order(bit=IF)=%b expected 10 grants 1000010000", ngnt, order);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL starve_end_idle: got busy=%b expected 0", busy);
    end
    step();
  endtask

  task automatic test_misaligned();
    ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h0000_0022;
    @(negedge clk);
    checks++;
    if ({ls_gnt, if_gnt} !== 2'b10) begin
      errors++; $display("FAIL misalign_gnt: got ls/if=%b expected 10", {ls_gnt, if_gnt});
    end
    step();
    ls_req = 1'b0;
    @(negedge clk);
    checks++;
    if ({mem_req_valid, ls_rvalid, ls_err, if_rvalid, ls_rdata} !== {4'b0110, 32'd0}) begin
      errors++; $display("FAIL misalign_resp: got v/rv/err/ifrv=%b data=%h expected 0110 data=0",
                         {mem_req_valid, ls_rvalid, ls_err, if_rvalid}, ls_rdata);
    end
    step();
    @(negedge clk);
    checks++;
    if ({busy, ls_rvalid, mem_req_valid} !== 3'b000) begin
      errors++; $display("FAIL misalign_idle: got busy/rv/v=%b expected 000", {busy, ls_rvalid, mem_req_valid});
    end
  endtask

  task automatic test_timeout();
    int early;
    early = 0;
    step();
    if_req = 1'b1; if_addr = 32'h0000_0040; mem_req_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (if_gnt !== 1'b1) begin
      errors++; $display("FAIL timeout_gnt: got %b expected 1", if_gnt);
    end
    step();
    if_req = 1'b0; if_addr = 32'h0000_0000;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if ({mem_req_valid, mem_addr} !== {1'b1, 32'h0000_0040}) begin
        errors++; $display("FAIL backpressure_hold: cycle %0d got v=%b addr=%h expected 1 00000040",
                           c, mem_req_valid, mem_addr);
      end
      step();
    end
    mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      if (if_rvalid !== 1'b0 || busy !== 1'b1) early++;
      step();
    end
    checks++;
    if (early != 0) begin
      errors++; $display("FAIL timeout_early: got %0d early responses/idle cycles expected 0", early);
    end
    @(negedge clk);
    checks++;
    if ({if_rvalid, if_err, if_rdata} !== {2'b11, 32'd0}) begin
      errors++; $display("FAIL timeout_resp: got rv/err=%b data=%h expected 11 data=0", {if_rvalid, if_err}, if_rdata);
    end
    step();
    mem_rsp_valid = 1'b1; mem_rdata = 32'h0000_0BAD;
    @(negedge clk);
    step();
    mem_rsp_valid = 1'b0; mem_rdata = 32'd0;
    @(negedge clk);
    checks++;
    if ({busy, if_rvalid, ls_rvalid} !== 3'b000) begin
      errors++; $display("FAIL late_rsp_ignored: got busy/ifrv/lsrv=%b expected 000", {busy, if_rvalid, ls_rvalid});
    end
  endtask

  task automatic test_reset_mid_wait();
    step();
    if_req = 1'b1; if_addr = 32'h0000_0080;
    step();
    if_req = 1'b0; mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
    step();
    if_req = 1'b1; if_addr = 32'h0000_0004;
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (all_out !== 137'd0) begin
      errors++; $display("FAIL reset_async: got %h expected 0", all_out);
    end
    if_req = 1'b0; mem_rsp_valid = 1'b1; mem_rdata = 32'h0000_0077;
    @(negedge clk);
    reset_n = 1'b1;
    step();
    @(negedge clk);
    checks++;
    if ({busy, if_rvalid, ls_rvalid} !== 3'b000) begin
      errors++; $display("FAIL reset_stale_rsp: got busy/ifrv/lsrv=%b expected 000", {busy, if_rvalid, ls_rvalid});
    end
    step();
    mem_rsp_valid = 1'b0;
    if_req = 1'b1; if_addr = 32'h0000_0000;
    @(negedge clk);
    checks++;
    if (if_gnt !== 1'b1) begin
      errors++; $display("FAIL post_reset_gnt: got %b expected 1", if_gnt);
    end
    step();
    if_req = 1'b0; mem_req_ready = 1'b1;
    @(negedge clk);
    checks++;
    if ({mem_req_valid, mem_addr} !== {1'b1, 32'h0000_0000}) begin
      errors++; $display("FAIL post_reset_req: got v=%b addr=%h expected 1 00000000", mem_req_valid, mem_addr);
    end
    step();
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b1; mem_rdata = 32'hCAFE_0001;
    step();
    mem_rsp_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({if_rvalid, if_err, if_rdata} !== {2'b10, 32'hCAFE_0001}) begin
      errors++; $display("FAIL post_reset_resp: got rv/err=%b data=%h expected 10 data=cafe0001",
                         {if_rvalid, if_err}, if_rdata);
    end
    step();
  endtask

  initial begin
    test_reset();
    test_single_fetch();
    test_simultaneous();
    test_starvation();
    test_misaligned();
    test_timeout();
    test_reset_mid_wait();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/unified_mem_arbiter.md
Name: unified_mem_arbiter

Overview:
- Shares one single-ported, variable-latency memory bus between the instruction-fetch requester (IF) and the load/store requester (LS) of the RV32 core.
- Sequences one transaction at a time: grant, issue with valid/ready, wait for response, return the response.
- LS has priority, with a starvation guard for IF, a response timeout, and misalignment trapping.
- Sits between the core's fetch/LSU ports and the unified memory.

Parameters:
- STARVE_LIMIT, 4: consecutive LS grants allowed while if_req is pending before IF is forced to win (legal range ≥1).
- TIMEOUT, 16: maximum number of cycles spent in WAIT before an error response is returned (legal range ≥2).

Ports:
- clk  in  1  clock
- reset_n  in  1  reset, asynchronous, active-low
- if_req  in  1  fetch request, level; held until if_gnt
- if_addr  in  32  fetch byte address
- if_gnt  out  1  fetch accepted this cycle
- if_rvalid  out  1  fetch response, 1-cycle pulse
- if_rdata  out  32  fetch data
- if_err  out  1  fetch error, qualified by if_rvalid
- ls_req  in  1  load/store request, level; held until ls_gnt
- ls_we  in  1  1 = store
- ls_addr  in  32  load/store byte address
- ls_wdata  in  32  store data
- ls_gnt  out  1  load/store accepted this cycle
- ls_rvalid  out  1  load/store response, 1-cycle pulse; stores also respond
- ls_rdata  out  32  load data; 0 for stores
- ls_err  out  1  load/store error, qualified by ls_rvalid
- mem_req_valid  out  1  memory request valid
- mem_req_ready  in  1  memory accepts request
- mem_we  out  1  memory write enable
- mem_addr  out  32  memory byte address
- mem_wdata  out  32  memory write data
- mem_rsp_valid  in  1  memory response, 1-cycle pulse
- mem_rdata  in  32  memory read data
- busy  out  1  1 whenever state ≠ IDLE

Behaviour:
- Reset (reset_n=0, asynchronous):
  - state=IDLE; starve_cnt=0; wait_cnt=0.
  - Every output is 0 immediately, including mem_req_valid. An in-flight transaction is abandoned.
  - After reset, a mem_rsp_valid that was outstanding is ignored.
- States: IDLE, REQ, WAIT, RESP.
- IDLE arbitration:
  - if_gnt and ls_gnt are combinational from state and the req inputs; only in IDLE; at most one is high.
  - Winner is LS when ls_req=1, unless if_req=1 and starve_cnt==STARVE_LIMIT, in which case IF wins.
  - On the grant edge, capture owner, addr, we, and wdata (we=0 and wdata=0 for IF).
  - Aligned address (addr[1:0]==0) → REQ. Misaligned → RESP with err=1, no memory access.
- starve_cnt:
  - Increments on each LS grant while if_req=1; saturates at STARVE_LIMIT.
  - Clears on an IF grant.
  - Clears on any LS grant while if_req=0.
- REQ:
  - mem_req_valid=1, with mem_addr, mem_we, and mem_wdata driven from the captured registers.
  - All three stay stable until the handshake.
  - On mem_req_ready=1 → WAIT and wait_cnt=0. mem_req_valid is never dropped before ready.
- WAIT:
  - On mem_rsp_valid=1: capture mem_rdata (forced to 0 for stores), err=0, → RESP.
  - Otherwise wait_cnt increments. If wait_cnt==TIMEOUT-1 → RESP with err=1 and rdata=0.
- RESP:
  - The owner's rvalid=1 for exactly one cycle, with its rdata and err.
  - The other port's rvalid, rdata, and err stay 0.
  - Next state IDLE. No grant is issued in RESP.
- mem_rsp_valid asserted in IDLE, REQ, or RESP is ignored. It is not forwarded and causes no state change.
- Latency, grant at cycle T:
  - mem_req_valid at T+1.
  - Earliest response: ready at T+1, rsp at T+2, rvalid at T+3.
  - Next grant no earlier than T+4.
  - Misaligned request: rvalid/err at T+1.
- The requester must hold req, addr, we, and wdata stable until its gnt. Deasserting req before gnt withdraws the request legally.

Test Plan:
- Single fetch: if_req=1, if_addr=0x10; ready=1 at T+1; rsp at T+2 with rdata 0x00500093 → if_gnt at T; mem_req_valid at T+1 with addr 0x10, we=0; if_rvalid at T+3 with rdata 0x00500093, err=0; busy=1 for T+1..T+3.
- Simultaneous requests: if_req (0x04) and ls_req store at 0x20, wdata 0xDEADBEEF → ls_gnt first; mem_we=1, mem_wdata=0xDEADBEEF; ls_rvalid with rdata 0; then if_gnt in the following IDLE cycle.
- Starvation: STARVE_LIMIT=4; ls_req and if_req held high continuously; one-cycle memory responses → grant order LS,LS,LS,LS,IF,LS…; never 5 consecutive LS grants while if_req=1.
- Misaligned: ls_req load at 0x22 → ls_gnt at T; mem_req_valid stays 0; ls_rvalid=1 at T+1 with ls_err=1, ls_rdata=0.
- Backpressure/timeout: mem_req_ready=0 for 3 cycles → mem_req_valid and mem_addr held stable. Then no response with TIMEOUT=16 → err response exactly 16 cycles after entering WAIT, with rdata 0. A late mem_rsp_valid in IDLE is ignored.
- Reset mid-WAIT: reset_n pulsed low → all outputs 0 asynchronously; state IDLE. A new fetch at 0x0 then completes normally with err=0.
